// File: rtl/countdown_ift.sv
// countdown_ift: 4-bit load/decrement countdown FSM with per-signal taint tracking.
// Define IFT_IMPLICIT_FLOW_EN to also taint state from load/en on untaken branches.
module countdown_ift (
  input  logic        clk,
  input  logic [31:0] clk_t,
  input  logic        rst,
  input  logic [31:0] rst_t,
  input  logic        load,
  input  logic [31:0] load_t,
  input  logic [3:0]  load_val,
  input  logic [31:0] load_val_t,
  input  logic        en,
  input  logic [31:0] en_t,
  output logic [3:0]  count,
  output logic [31:0] count_t,
  output logic        busy,
  output logic [31:0] busy_t,
  output logic        zero,
  output logic [31:0] zero_t
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e      r_state, w_state_n;
  logic [31:0] r_state_t, w_state_t_n, w_count_t_n, w_zero_t_n, w_ld_t;
  logic [3:0]  w_count_n;
  logic        w_zero_n, w_last;
  logic        w_unused;
  assign w_unused = ^clk_t;
  assign busy     = r_state == RUN;
  assign busy_t   = r_state_t;
  assign w_ld_t   = load_val_t | load_t;
  assign w_last   = count == 4'd1;
  always_comb begin
    w_state_n   = r_state;
    w_state_t_n = r_state_t;
    w_count_n   = count;
    w_count_t_n = count_t;
    w_zero_n    = 1'b0;
    w_zero_t_n  = zero_t;
    if (load) begin
      w_count_n   = load_val;
      w_count_t_n = w_ld_t;
      w_state_t_n = w_ld_t;
      w_state_n   = load_val != 4'd0 ? RUN : DONE;
      w_zero_n    = load_val == 4'd0;
      w_zero_t_n  = load_val == 4'd0 ? w_ld_t : zero_t;
    end else if (r_state == RUN && en) begin
      w_count_n   = count - 4'd1;
      w_count_t_n = count_t | en_t;
      w_state_t_n = r_state_t | en_t;
      w_state_n   = w_last ? DONE : RUN;
      w_zero_n    = w_last;
      w_zero_t_n  = w_last ? count_t | en_t : zero_t;
    end else if (r_state == DONE) begin
      w_state_n = IDLE;
    end
`ifdef IFT_IMPLICIT_FLOW_EN
    // control inputs that could have steered the update taint it even when not taken
    w_count_t_n = w_count_t_n | load_t | (r_state == RUN ? en_t : 32'd0);
    w_state_t_n = w_state_t_n | load_t | (r_state == RUN ? en_t : 32'd0);
    w_zero_t_n  = w_zero_t_n  | load_t | (r_state == RUN ? en_t : 32'd0);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_state_t <= rst_t;
      count     <= 4'd0;
      count_t   <= rst_t;
      zero      <= 1'b0;
      zero_t    <= rst_t;
    end else begin
      r_state   <= w_state_n;
      r_state_t <= w_state_t_n;
      count     <= w_count_n;
      count_t   <= w_count_t_n;
      zero      <= w_zero_n;
      zero_t    <= w_zero_t_n;
    end
  end
endmodule

// File: tb/tb_countdown_ift.sv
// tb_countdown_ift: directed and randomized checks of countdown_ift against a behavioural model.
module tb_countdown_ift;
  logic        clk = 1'b0, rst = 1'b0, load = 1'b0, en = 1'b0;
  logic [3:0]  load_val = 4'd0;
  logic [31:0] clk_t = '0, rst_t = '0, load_t = '0, load_val_t = '0, en_t = '0;
  logic [3:0]  count;
  logic [31:0] count_t, busy_t, zero_t;
  logic        busy, zero;
  int          n_chk = 0, n_pass = 0;
  int          m_cnt = 0;
  logic [31:0] m_cnt_t = '0, m_st_t = '0, m_zero_t = '0, m_imp;
  bit          m_zero = 0, m_run = 0, m_done = 0;

  countdown_ift dut (
    .clk(clk), .clk_t(clk_t), .rst(rst), .rst_t(rst_t), .load(load), .load_t(load_t),
    .load_val(load_val), .load_val_t(load_val_t), .en(en), .en_t(en_t),
    .count(count), .count_t(count_t), .busy(busy), .busy_t(busy_t), .zero(zero), .zero_t(zero_t)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model();
    logic [31:0] t;
    if (rst) begin
      m_cnt = 0; m_cnt_t = rst_t; m_st_t = rst_t; m_zero = 0; m_zero_t = rst_t;
      m_run = 0; m_done = 0;
    end else begin
      m_imp = load_t | (m_run ? en_t : 32'd0);
      if (load) begin
        t = load_val_t | load_t;
        m_cnt = int'(load_val); m_cnt_t = t; m_st_t = t;
        m_run = load_val > 0; m_done = load_val == 0; m_zero = load_val == 0;
        if (load_val == 0) m_zero_t = t;
      end else if (m_run && en) begin
        m_cnt = m_cnt - 1; m_cnt_t |= en_t; m_st_t |= en_t;
        m_zero = m_cnt == 0;
        if (m_cnt == 0) begin
          m_run = 0; m_done = 1; m_zero_t = m_cnt_t;
        end
      end else begin
        m_done = 0; m_zero = 0;
      end
`ifdef IFT_IMPLICIT_FLOW_EN
      m_cnt_t |= m_imp; m_st_t |= m_imp; m_zero_t |= m_imp;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("count", 32'(count), 32'(m_cnt));
    chk("count_t", count_t, m_cnt_t);
    chk("busy", 32'(busy), 32'(m_run));
    chk("busy_t", busy_t, m_st_t);
    chk("zero", 32'(zero), 32'(m_zero));
    chk("zero_t", zero_t, m_zero_t);
  endtask

  function automatic logic [31:0] rnd_taint();
    return ($urandom_range(3, 0) == 0) ? (32'd1 << $urandom_range(31, 0)) : 32'd0;
  endfunction

  initial begin
    rst = 1; rst_t = 32'h4;
    tick();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_count_t", count_t, 32'h4);
    chk("reset_busy_t", busy_t, 32'h4);
    rst = 0; rst_t = 0;
    load = 1; load_val = 4'd3; load_val_t = 32'h1;
    tick();
    load = 0; load_val_t = 0; en = 1; en_t = 32'h10;
    tick();
    tick();
    chk("run_count1", 32'(count), 32'd1);
    tick();
    chk("term_zero", 32'(zero), 32'd1);
    chk("term_zero_t", zero_t, 32'h11);
    en = 0; en_t = 0;
    tick();
    chk("after_term_busy", 32'(busy), 32'd0);
    chk("after_term_zero", 32'(zero), 32'd0);
    load = 1; load_val = 4'd0;
    tick();
    chk("zero_load_pulse", 32'(zero), 32'd1);
    chk("zero_load_busy", 32'(busy), 32'd0);
    load = 0;
    tick();
    load = 1; load_val = 4'd5;
    tick();
    load = 0; en = 1;
    tick();
    tick();
    load = 1; load_val = 4'd2;
    tick();
    chk("reload_count", 32'(count), 32'd2);
    load = 0; en = 0;
    tick();
    rst = 1;
    tick();
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    rst = 0;
    en = 1; en_t = 32'h80;
    repeat (5) tick();
    chk("idle_en_count", 32'(count), 32'd0);
    en = 0; en_t = 0;
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(39, 0) == 0;
      load = $urandom_range(7, 0) == 0;
      en = $urandom_range(1, 0) == 1;
      load_val = 4'($urandom_range(15, 0));
      rst_t = rnd_taint(); load_t = rnd_taint(); load_val_t = rnd_taint(); en_t = rnd_taint();
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
